run_ctrl: RTL and testbench

- Synthesizable run-control unit that sits between the top level and one or more CPU cores.
- Sequences core reset, gates core execution, and supports free-run and single-step modes.
- Detects halt across NUM_CORES cores, enforces a programmable cycle timeout, and keeps cycle and per-core retired-instruction counters.
- Generalises halt-to-exit detection into a parametrised, multi-core, timeout-guarded controller.

---
 rtl/run_ctrl.sv | 120 ++++++++++++
 tb/tb_run_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: sequences core reset, gates core execution (free-run or single-step),
//   detects all-core halt and cycle timeout, and counts enabled cycles and retires.
// Latency: all outputs registered; a decision made in cycle N is visible after edge N.
//   No backpressure: start/step_req are single-cycle pulses, ignored outside the states that accept them.
// Ports:
//   clk, reset (async active-low)     - clock and reset
//   start, mode_step, step_req        - run control pulses; mode_step sampled with start
//   halt_in, retire_in                - per-core halt level / retire strobe
//   timeout_cycles                    - live cycle limit, 0 disables
//   core_reset, core_en               - reset and run gate to the cores
//   done, timed_out, halted           - run status (held in DONE until next start)
//   cycle_count, retire_count         - counters; core i at retire_count[i*CNT_W +: CNT_W]
module run_ctrl #(
  parameter int NUM_CORES  = 1,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode_step,
  input  logic                         step_req,
  input  logic [NUM_CORES-1:0]         halt_in,
  input  logic [NUM_CORES-1:0]         retire_in,
  input  logic [CNT_W-1:0]             timeout_cycles,
  output logic                         core_reset,
  output logic                         core_en,
  output logic                         done,
  output logic                         timed_out,
  output logic [NUM_CORES-1:0]         halted,
  output logic [CNT_W-1:0]             cycle_count,
  output logic [NUM_CORES*CNT_W-1:0]   retire_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RHOLD, S_RUN, S_PAUSE, S_STEP, S_DONE
  } state_t;

  localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t          state_q, state_d;
  logic [RC_W-1:0] rc_q;
  logic            step_mode_q;

  logic begin_run;
  logic all_halt;
  logic tmo_hit;
  logic core_reset_d, core_en_d, done_d;

  // core_en mirrors RUN/STEP, so it marks the cycles the cores actually execute.
  // A core that halts this cycle counts towards completion via halt_in.
  assign all_halt  = core_en && (&(halted | halt_in));
  // Fires on the last permitted enabled cycle; completion takes priority.
  assign tmo_hit   = core_en && (timeout_cycles != '0) &&
                     (cycle_count == (timeout_cycles - CNT_ONE)) && !all_halt;
  assign begin_run = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RHOLD;
      S_RHOLD:        if (rc_q == RC_LAST) state_d = step_mode_q ? S_PAUSE : S_RUN;
      S_RUN:          if (all_halt || tmo_hit) state_d = S_DONE;
      S_PAUSE:        if (step_req) state_d = S_STEP;
      S_STEP:         state_d = (all_halt || tmo_hit) ? S_DONE : S_PAUSE;
      default:        state_d = S_IDLE;
    endcase
    core_reset_d = (state_d == S_IDLE) || (state_d == S_RHOLD);
    core_en_d    = (state_d == S_RUN)  || (state_d == S_STEP);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rc_q        <= '0;
      step_mode_q <= 1'b0;
      core_reset  <= 1'b1;
      core_en     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_reset <= core_reset_d;
      core_en    <= core_en_d;
      done       <= done_d;
      if (begin_run) begin
        rc_q        <= '0;
        step_mode_q <= mode_step;
      end else if (state_q == S_RHOLD && rc_q != RC_LAST) begin
        rc_q <= rc_q + RC_W'(1);
      end
    end
  end

  // Counters and sticky status: cleared at run start, advanced only on enabled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timed_out    <= 1'b0;
      halted       <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else if (begin_run) begin
      timed_out    <= 1'b0;
      halted       <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else if (core_en) begin
      if (cycle_count != '1) cycle_count <= cycle_count + CNT_ONE;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (retire_in[i] && !halted[i] && (retire_count[i*CNT_W +: CNT_W] != '1))
          retire_count[i*CNT_W +: CNT_W] <= retire_count[i*CNT_W +: CNT_W] + CNT_ONE;
      end
      halted <= halted | halt_in;
      if (tmo_hit) timed_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic        mode_step = 1'b0, step_req = 1'b0;
  logic [0:0]  halt1 = '0, retire1 = '0;
  logic [2:0]  halt3 = '0, retire3 = '0;
  logic [31:0] timeout_cycles = '0;

  logic        core_reset1, core_en1, done1, timed_out1;
  logic [0:0]  halted1;
  logic [31:0] cycle_count1, retire_count1;
  logic        core_reset3, core_en3, done3, timed_out3;
  logic [2:0]  halted3;
  logic [31:0] cycle_count3;
  logic [95:0] retire_count3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  run_ctrl #(.NUM_CORES(1), .CNT_W(32), .RST_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode_step(mode_step), .step_req(step_req),
    .halt_in(halt1), .retire_in(retire1), .timeout_cycles(timeout_cycles),
    .core_reset(core_reset1), .core_en(core_en1), .done(done1), .timed_out(timed_out1),
    .halted(halted1), .cycle_count(cycle_count1), .retire_count(retire_count1));

  run_ctrl #(.NUM_CORES(3), .CNT_W(32), .RST_CYCLES(2)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .mode_step(mode_step), .step_req(step_req),
    .halt_in(halt3), .retire_in(retire3), .timeout_cycles(timeout_cycles),
    .core_reset(core_reset3), .core_en(core_en3), .done(done3), .timed_out(timed_out3),
    .halted(halted3), .cycle_count(cycle_count3), .retire_count(retire_count3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Free run on the single-core DUT; halt_in rises on enabled cycle halt_at (0 = never).
  task automatic run1(input int halt_at, input logic [31:0] tmo, output int en_n, output int rh_n);
    timeout_cycles = tmo; mode_step = 1'b0; retire1 = 1'b1; halt1 = 1'b0;
    en_n = 0; rh_n = 0;
    start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
    for (int c = 0; c < 200 && !done1; c++) begin
      if (core_reset1) rh_n++;
      if (core_en1) begin
        en_n++;
        halt1 = (halt_at != 0 && en_n >= halt_at);
      end else begin
        halt1 = 1'b0;
      end
      @(posedge clk); #1;
    end
    halt1 = 1'b0;
    chk("run1_reached_done", done1, 1);
  endtask

  typedef struct {
    logic start; logic halt; logic retire;
    logic exp_rst; logic exp_en; logic exp_done; int exp_cnt; int exp_ret;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int en_n, rh_n;
    logic prev_en;
    int b2b;

    // Single core, free run, halt on the 10th enabled cycle, retire every cycle.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
    for (int k = 1; k <= 9; k++) tbl[2+k] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, k, k};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10, 10};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10, 10};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_reset", core_reset1, 1);
    chk("rst_core_en", core_en1, 0);
    chk("rst_done", done1, 0);
    chk("rst_timed_out", timed_out1, 0);
    chk("rst_cycle_count", cycle_count1, 0);
    chk("rst_halted3", halted3, 0);
    chk("rst_retire3", retire_count3, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      start1 = tbl[i].start; halt1 = tbl[i].halt; retire1 = tbl[i].retire;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_core_reset", i), core_reset1, tbl[i].exp_rst);
      chk($sformatf("vec%0d_core_en", i), core_en1, tbl[i].exp_en);
      chk($sformatf("vec%0d_done", i), done1, tbl[i].exp_done);
      chk($sformatf("vec%0d_cycle_count", i), cycle_count1, tbl[i].exp_cnt);
      chk($sformatf("vec%0d_retire", i), retire_count1, tbl[i].exp_ret);
    end
    start1 = 1'b0; halt1 = 1'b0;
    chk("free_timed_out", timed_out1, 0);
    chk("free_halted", halted1, 1);

    // Timeout after 5 enabled cycles, no halt.
    run1(0, 32'd5, en_n, rh_n);
    chk("tmo_en_cycles", en_n, 5);
    chk("tmo_rst_cycles", rh_n, 2);
    chk("tmo_timed_out", timed_out1, 1);
    chk("tmo_cycle_count", cycle_count1, 5);
    chk("tmo_retire", retire_count1, 5);
    chk("tmo_halted", halted1, 0);

    // Halt coincides with timeout: completion wins.
    run1(8, 32'd8, en_n, rh_n);
    chk("tie_en_cycles", en_n, 8);
    chk("tie_timed_out", timed_out1, 0);
    chk("tie_cycle_count", cycle_count1, 8);
    chk("tie_halted", halted1, 1);

    // Three cores halting at 4, 7, 12.
    timeout_cycles = 32'd0; retire3 = 3'b111; halt3 = 3'b000;
    start3 = 1'b1; @(posedge clk); #1; start3 = 1'b0;
    en_n = 0;
    for (int c = 0; c < 200 && !done3; c++) begin
      if (core_en3) begin
        if (en_n == 4) chk("mc_halted_after4", halted3, 3'b001);
        if (en_n == 7) chk("mc_halted_after7", halted3, 3'b011);
        en_n++;
        halt3 = {en_n >= 12, en_n >= 7, en_n >= 4};
      end
      @(posedge clk); #1;
    end
    halt3 = 3'b000;
    chk("mc_done", done3, 1);
    chk("mc_en_cycles", en_n, 12);
    chk("mc_halted", halted3, 3'b111);
    chk("mc_cycle_count", cycle_count3, 12);
    chk("mc_retire0", retire_count3[31:0], 4);
    chk("mc_retire1", retire_count3[63:32], 7);
    chk("mc_retire2", retire_count3[95:64], 12);
    chk("mc_timed_out", timed_out3, 0);

    // Single-step: three step pulses, an extra request during STEP is dropped.
    timeout_cycles = 32'd0; retire1 = 1'b1; halt1 = 1'b0; step_req = 1'b0;
    mode_step = 1'b1; start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0; mode_step = 1'b0;
    en_n = 0; b2b = 0; prev_en = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) chk("step_first_en", core_en1, 1);
      if (k == 6) chk("step_req_in_step_ignored", core_en1, 0);
      if (core_en1) en_n++;
      if (core_en1 && prev_en) b2b++;
      prev_en = core_en1;
      step_req = (k == 4 || k == 5 || k == 8 || k == 12);
      @(posedge clk); #1;
    end
    step_req = 1'b0;
    chk("step_en_cycles", en_n, 3);
    chk("step_back_to_back", b2b, 0);
    chk("step_cycle_count", cycle_count1, 3);
    chk("step_retire", retire_count1, 3);
    chk("step_done", done1, 0);

    // start while paused has no effect.
    start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
    chk("start_ignored_core_reset", core_reset1, 0);
    chk("start_ignored_cycle_count", cycle_count1, 3);

    // Reset mid-run during the 6th enabled cycle, then restart.
    reset = 1'b0; #1; reset = 1'b1;
    @(posedge clk); #1;
    timeout_cycles = 32'd0; mode_step = 1'b0; retire1 = 1'b1;
    start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
    en_n = 0;
    for (int c = 0; c < 50; c++) begin
      if (core_en1) begin
        if (en_n == 5) break;
        en_n++;
      end
      @(posedge clk); #1;
    end
    chk("mid_pre_cycle_count", cycle_count1, 5);
    reset = 1'b0; #1;
    chk("mid_core_reset", core_reset1, 1);
    chk("mid_core_en", core_en1, 0);
    chk("mid_cycle_count", cycle_count1, 0);
    chk("mid_retire", retire_count1, 0);
    chk("mid_dut3_core_reset", core_reset3, 1);
    chk("mid_dut3_done", done3, 0);
    @(posedge clk); #1;
    chk("mid_held_core_reset", core_reset1, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    run1(3, 32'd0, en_n, rh_n);
    chk("restart_en_cycles", en_n, 3);
    chk("restart_rst_cycles", rh_n, 2);
    chk("restart_cycle_count", cycle_count1, 3);
    chk("restart_retire", retire_count1, 3);
    chk("restart_timed_out", timed_out1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
